// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file.
// Selects the write-back data and destination and writes the register array.
// Serves two combinational read ports and exports the resolved write-back bus.
// Counts committed register writes.
// Optional feature macro: WB_BYPASS_EN. When defined, a read of the register
// being written this cycle returns the new data (write-before-read).
module wb_register_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int JAL_REG = 31,
  parameter int CNT_W   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              inRegWrite,
  input  logic              inJalSel,
  input  logic [1:0]        inMemToReg,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic [DATA_W-1:0] inMemData,
  input  logic [DATA_W-1:0] inPcPlus8,
  input  logic [ADDR_W-1:0] inWriteRegister,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WbWriteEn,
  output logic [ADDR_W-1:0] WbRegister,
  output logic [DATA_W-1:0] WbData,
  output logic [CNT_W-1:0]  RetireCount
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] JAL_IDX = ADDR_W'(JAL_REG);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [CNT_W-1:0]  retire_count_reg;

  logic [DATA_W-1:0] wb_data_next;
  logic [ADDR_W-1:0] wb_register_next;
  logic              wb_write_en_next;

  // Write-back data select; jal overrides the MemToReg table, code 11 falls back to ALU.
  always_comb begin
    wb_data_next = inAluResult;
    if (inJalSel) begin
      wb_data_next = inPcPlus8;
    end else begin
      case (inMemToReg)
        2'b01:   wb_data_next = inMemData;
        2'b10:   wb_data_next = inPcPlus8;
        default: wb_data_next = inAluResult;
      endcase
    end
  end

  // Register 0 is never a real destination, so it is masked here and the
  // forwarding unit never sees it.
  assign wb_register_next = inJalSel ? JAL_IDX : inWriteRegister;
  assign wb_write_en_next = inRegWrite & (wb_register_next != '0);

  assign WbData     = wb_data_next;
  assign WbRegister = wb_register_next;
  assign WbWriteEn  = wb_write_en_next;

  // Register array: async clear, one write per cycle. Entry 0 is never written.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_write_en_next) begin
      regs_reg[wb_register_next] <= wb_data_next;
    end
  end

  // Retire counter: one count per committed write, wraps naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      retire_count_reg <= '0;
    end else if (wb_write_en_next) begin
      retire_count_reg <= retire_count_reg + CNT_W'(1);
    end
  end

  assign RetireCount = retire_count_reg;

  // Two identical read ports; index 0 is read port A, index 1 is read port B.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_read
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign addr = (gi == 0) ? ReadRegister1 : ReadRegister2;

`ifdef WB_BYPASS_EN
    assign hit = wb_write_en_next && (addr == wb_register_next);
`else
    assign hit = 1'b0;
`endif

    // Reads are forced to zero during reset and for register 0.
    always_comb begin
      data = '0;
      if (!Reset && (addr != '0)) begin
        data = hit ? wb_data_next : regs_reg[addr];
      end
    end
  end

  assign ReadData1 = gen_read[0].data;
  assign ReadData2 = gen_read[1].data;

endmodule
